// File: rtl/pwm_multichannel.sv
// N-channel PWM generator: button-driven shadow duties, edge/center counting,
// and shadow-to-active duty transfer at each period boundary.
`timescale 1ns/1ps
module pwm_multichannel #(
    parameter int CHANNELS        = 4,
    parameter int CH_BITS         = 2,
    parameter int RESOLUTION_BITS = 8,
    parameter int FRECUENCY_BITS  = 1,
    parameter int REPEAT_BITS     = 4
) (
    input  logic                       clk_top,
    input  logic                       rst_top,
    input  logic                       sum_top,
    input  logic                       rest_top,
    input  logic [CH_BITS-1:0]         sel_top,
    input  logic                       mode_top,
    output logic [CHANNELS-1:0]        pwm_top,
    output logic                       rdy_top,
    output logic [RESOLUTION_BITS-1:0] duty_top,
    output logic [RESOLUTION_BITS-1:0] cnt_top
);

    localparam logic [RESOLUTION_BITS-1:0] MAX = '1;

    logic [FRECUENCY_BITS-1:0]  presc;
    logic                       tick;
    logic [RESOLUTION_BITS-1:0] cnt;
    logic [RESOLUTION_BITS-1:0] cnt_next;
    logic                       dir;
    logic                       dir_next;
    logic                       mode_act;
    logic                       boundary;

    logic [RESOLUTION_BITS-1:0] shadow [CHANNELS];
    logic [RESOLUTION_BITS-1:0] active [CHANNELS];

    logic sum_s1, sum_s2, sum_prev;
    logic rest_s1, rest_s2, rest_prev;
    logic [REPEAT_BITS-1:0] hold;
    logic sum_only, rest_only, sum_only_prev, rest_only_prev;
    logic hold_run, repeat_hit, step_up, step_dn;

    assign tick = &presc;

    // dir is 0 when counting up; the boundary itself returns the counter to 0/up,
    // so the down phase never has to handle cnt==0.
    always_comb begin
        cnt_next = cnt + 1'b1;
        dir_next = 1'b0;
        if (mode_act && (dir || cnt == MAX)) begin
            cnt_next = cnt - 1'b1;
            dir_next = 1'b1;
        end
    end

    assign boundary = tick && (cnt_next == '0);

    always_ff @(posedge clk_top or negedge rst_top) begin
        if (!rst_top) begin
            presc    <= '0;
            cnt      <= '0;
            dir      <= 1'b0;
            mode_act <= 1'b0;
            rdy_top  <= 1'b0;
        end else begin
            presc   <= presc + 1'b1;
            rdy_top <= boundary;
            if (boundary) begin
                cnt      <= '0;
                dir      <= 1'b0;
                mode_act <= mode_top;
            end else if (tick) begin
                cnt <= cnt_next;
                dir <= dir_next;
            end
        end
    end

    always_ff @(posedge clk_top or negedge rst_top) begin
        if (!rst_top) begin
            pwm_top <= '0;
            for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_top[i] <= (cnt < active[i]);
                if (boundary) active[i] <= shadow[i];
            end
        end
    end

    // A held button repeats only while it is the sole button down in consecutive clocks.
    assign sum_only       = !sum_s2 && rest_s2;
    assign rest_only      = !rest_s2 && sum_s2;
    assign sum_only_prev  = !sum_prev && rest_prev;
    assign rest_only_prev = !rest_prev && sum_prev;
    assign hold_run       = (sum_only && sum_only_prev) || (rest_only && rest_only_prev);
    assign repeat_hit     = hold_run && (&hold);
    assign step_up        = sum_only && (sum_prev || repeat_hit);
    assign step_dn        = rest_only && (rest_prev || repeat_hit);

    always_ff @(posedge clk_top or negedge rst_top) begin
        if (!rst_top) begin
            sum_s1    <= 1'b1;
            sum_s2    <= 1'b1;
            sum_prev  <= 1'b1;
            rest_s1   <= 1'b1;
            rest_s2   <= 1'b1;
            rest_prev <= 1'b1;
            hold      <= '0;
        end else begin
            sum_s1    <= sum_top;
            sum_s2    <= sum_s1;
            sum_prev  <= sum_s2;
            rest_s1   <= rest_top;
            rest_s2   <= rest_s1;
            rest_prev <= rest_s2;
            hold      <= hold_run ? hold + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_top or negedge rst_top) begin
        if (!rst_top) begin
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_top == CH_BITS'(i)) begin
                    if (step_up && shadow[i] != MAX)
                        shadow[i] <= shadow[i] + 1'b1;
                    else if (step_dn && shadow[i] != '0)
                        shadow[i] <= shadow[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        duty_top = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (sel_top == CH_BITS'(i)) duty_top = shadow[i];
    end

    assign cnt_top = cnt;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomized bench for pwm_multichannel against a period-position reference model;
// a second 3-channel instance covers the out-of-range channel select.
`timescale 1ns/1ps
module tb_pwm_multichannel;

    logic       clk_top = 1'b0;
    logic       rst_top;
    logic       sum_top;
    logic       rest_top;
    logic [1:0] sel_top;
    logic       mode_top;
    logic [3:0] pwm_top;
    logic       rdy_top;
    logic [7:0] duty_top;
    logic [7:0] cnt_top;
    logic [2:0] pwm3;
    logic       rdy3;
    logic [7:0] duty3;
    logic [7:0] cnt3;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: position within the period, not a direction flag.
    int         m_edges;
    int         m_pos;
    int         m_mode;
    int         m_cnt;
    logic       m_rdy;
    logic [3:0] m_pwm;
    int         m_sh  [4];
    int         m_act [4];
    int         m_sh3 [3];
    logic       m_hs  [3];
    logic       m_hr  [3];
    int         m_prev_state;
    int         m_streak;

    pwm_multichannel dut (
        .clk_top(clk_top), .rst_top(rst_top), .sum_top(sum_top), .rest_top(rest_top),
        .sel_top(sel_top), .mode_top(mode_top), .pwm_top(pwm_top), .rdy_top(rdy_top),
        .duty_top(duty_top), .cnt_top(cnt_top)
    );

    pwm_multichannel #(.CHANNELS(3)) dut3 (
        .clk_top(clk_top), .rst_top(rst_top), .sum_top(sum_top), .rest_top(rest_top),
        .sel_top(sel_top), .mode_top(mode_top), .pwm_top(pwm3), .rdy_top(rdy3),
        .duty_top(duty3), .cnt_top(cnt3)
    );

    always #5 clk_top = ~clk_top;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        m_edges = 0; m_pos = 0; m_mode = 0; m_cnt = 0; m_rdy = 1'b0; m_pwm = '0;
        for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        for (int i = 0; i < 3; i++) begin m_sh3[i] = 0; m_hs[i] = 1'b1; m_hr[i] = 1'b1; end
        m_prev_state = 0;
        m_streak = 0;
    endtask

    // One rising edge: button levels seen by the step logic are the pins two and
    // three edges back; a counter tick happens on every second edge after reset.
    task automatic modelEdge();
        int state;
        int step;
        logic fall;
        for (int i = 0; i < 4; i++) m_pwm[i] = (m_cnt < m_act[i]);
        m_edges++;
        state = (!m_hs[1] && m_hr[1]) ? 1 : ((!m_hr[1] && m_hs[1]) ? 2 : 0);
        step = 0;
        if (state != 0) begin
            m_streak = (state == m_prev_state) ? m_streak + 1 : 0;
            fall = (state == 1) ? m_hs[2] : m_hr[2];
            if ((m_streak == 0 && fall) || (m_streak > 0 && m_streak % 16 == 0)) step = state;
        end
        m_prev_state = state;
        m_hs[2] = m_hs[1]; m_hs[1] = m_hs[0]; m_hs[0] = sum_top;
        m_hr[2] = m_hr[1]; m_hr[1] = m_hr[0]; m_hr[0] = rest_top;
        m_rdy = 1'b0;
        if (m_edges % 2 == 0) begin
            m_pos++;
            if (m_pos == (m_mode != 0 ? 510 : 256)) begin
                m_pos = 0;
                m_rdy = 1'b1;
                m_act = m_sh;
                m_mode = int'(mode_top);
            end
        end
        if (step == 1) begin
            m_sh[sel_top] = (m_sh[sel_top] < 255) ? m_sh[sel_top] + 1 : 255;
            if (sel_top < 3) m_sh3[sel_top] = (m_sh3[sel_top] < 255) ? m_sh3[sel_top] + 1 : 255;
        end else if (step == 2) begin
            m_sh[sel_top] = (m_sh[sel_top] > 0) ? m_sh[sel_top] - 1 : 0;
            if (sel_top < 3) m_sh3[sel_top] = (m_sh3[sel_top] > 0) ? m_sh3[sel_top] - 1 : 0;
        end
        m_cnt = (m_mode != 0 && m_pos > 255) ? 510 - m_pos : m_pos;
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [1:0] sel,
                                 input logic m, input int cycles);
        sum_top = s; rest_top = r; sel_top = sel; mode_top = m;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk_top);
            modelEdge();
            @(negedge clk_top);
            checkOutput("cnt", 32'(cnt_top), 32'(m_cnt));
            checkOutput("rdy", 32'(rdy_top), 32'(m_rdy));
            checkOutput("pwm", 32'(pwm_top), 32'(m_pwm));
            checkOutput("duty", 32'(duty_top), 32'(m_sh[sel_top]));
            checkOutput("duty3", 32'(duty3), (sel_top < 3) ? 32'(m_sh3[sel_top]) : 32'd0);
            #2;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pwm"}, 32'(pwm_top), 32'd0);
        checkOutput({tag, "_rdy"}, 32'(rdy_top), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(cnt_top), 32'd0);
        checkOutput({tag, "_duty"}, 32'(duty_top), 32'd0);
    endtask

    initial begin
        logic [1:0] pat;
        rst_top = 1'b0; sum_top = 1'b1; rest_top = 1'b1; sel_top = '0; mode_top = 1'b0;
        modelReset();
        #13;
        checkResetOutputs("reset");
        @(negedge clk_top); #2;
        rst_top = 1'b1;
        $display("[TB] reset released, idle period");
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1100);

        $display("[TB] single press and held press");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 600);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 40);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 600);

        $display("[TB] saturation and conflict cases");
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 50);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 4200);
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 5);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 10);

        $display("[TB] center-aligned mode, channel 0 to 64");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 995);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 2200);

        $display("[TB] randomized button traffic");
        for (int k = 0; k < 40; k++) begin
            pat = 2'($urandom_range(0, 3));
            applyStimulus(pat[0], pat[1], 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), int'($urandom_range(1, 80)));
        end
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 400);

        $display("[TB] short asynchronous reset pulse");
        rst_top = 1'b0;
        modelReset();
        #0.5;
        checkResetOutputs("pulse");
        #0.5;
        rst_top = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
- N-channel PWM generator with per-channel duty registers.
- Duty of the selected channel is adjusted by active-low sum/rest push-buttons, with auto-repeat while a button is held.
- Supports edge-aligned and center-aligned counting, a power-of-two prescaler, and glitch-free shadow-to-active duty update at period boundaries.
- Successor of the single-channel generator; sits between the button inputs and the motor/LED drive outputs, and feeds the display path via duty_top.

Parameters:
- CHANNELS, 4, number of PWM outputs (1..16).
- CH_BITS, 2, width of channel select; 2^CH_BITS >= CHANNELS.
- RESOLUTION_BITS, 8, duty/counter width; MAX = 2^RESOLUTION_BITS-1.
- FRECUENCY_BITS, 1, prescaler width; counter tick every 2^FRECUENCY_BITS clocks (>=1).
- REPEAT_BITS, 4, auto-repeat interval while a button is held = 2^REPEAT_BITS clocks.

Ports:
- clk_top  in  1  system clock, rising edge.
- rst_top  in  1  asynchronous, active-low reset.
- sum_top  in  1  increment button, active-low, asynchronous to clk.
- rest_top  in  1  decrement button, active-low, asynchronous to clk.
- sel_top  in  CH_BITS  channel whose duty the buttons modify.
- mode_top  in  1  0 = edge-aligned, 1 = center-aligned.
- pwm_top  out  CHANNELS  PWM outputs, registered.
- rdy_top  out  1  one-clock pulse at each period boundary.
- duty_top  out  RESOLUTION_BITS  shadow duty of channel sel_top.
- cnt_top  out  RESOLUTION_BITS  current PWM counter.

Behaviour:
Reset (rst_top=0, immediate, no clock required):
- cnt=0, dir=up, prescaler=0, mode_act=0.
- All shadow and active duties = 0.
- pwm_top=0, rdy_top=0.
- Button synchronizers = 1 (released); hold counter = 0.

Prescaler:
- Free-running FRECUENCY_BITS counter.
- tick is asserted in the clock where the prescaler is all-ones.

Edge mode:
- On tick, cnt increments 0..MAX and wraps MAX->0.
- Period = (MAX+1) ticks.

Center mode:
- On tick, cnt runs 0 up to MAX, then down to 0.
- dir flips to down at MAX and to up at 0.
- Period = 2*MAX ticks.

PWM output:
- pwm_top[i] registered as (cnt < duty_act[i]), updated every clock.
- duty 0 gives constant low.
- duty MAX is low only while cnt==MAX.

Period boundary:
- Defined as the tick on which cnt becomes 0.
- Registered on that same edge: duty_act[*] <= duty_shadow[*] and mode_act <= mode_top.
- Counting always uses mode_act, never mode_top directly.
- On a mode change at a boundary, cnt restarts at 0 with dir=up.
- rdy_top is high for exactly the one clock in which cnt first reads 0.

Buttons:
- Each button goes through a 2-FF synchronizer.
- A press is a synchronized 1->0 edge and produces one step on the following edge. Shadow therefore changes 3 clocks after the pin falls.
- While the synchronized level stays 0, the hold counter runs; each wrap of 2^REPEAT_BITS clocks produces another step. Release clears the counter.
- sum step: shadow[sel]+1, saturating at MAX.
- rest step: shadow[sel]-1, saturating at 0. Never wraps.
- Both buttons low simultaneously: no steps, hold counter cleared.
- sel_top is sampled in the step clock.
- sel_top >= CHANNELS: steps ignored, duty_top = 0.

Output timing:
- duty_top is combinational from the shadow registers.
- cnt_top = cnt.
- Shadow changes never alter pwm_top before the next boundary.

Reset mid-operation:
- Asserting rst_top mid-period drives all outputs low immediately.
- After release, counting restarts from cnt=0; the first rdy_top pulse occurs at the end of a full period.

Test Plan:
(Defaults: CHANNELS=4, RESOLUTION_BITS=8, FRECUENCY_BITS=1, REPEAT_BITS=4.)
1. Reset, then idle 1100 clocks:
   - pwm_top = 4'b0000 and duty_top = 0 throughout.
   - rdy_top pulses every 512 clocks; cnt_top wraps 255->0.
2. sel=0, sum_top low for 3 clocks then high:
   - duty_top = 1 on the 3rd edge after the fall.
   - pwm_top[0] stays 0 until the next rdy_top, then is high for 2 clocks per 512-clock period.
3. sel=1, sum_top held low for 40 clocks:
   - duty_top = 3 (initial step plus repeats 16 and 32 clocks later).
   - pwm_top[1] high for 6 clocks per period from the following boundary; other channels unaffected.
4. Boundary and conflict cases:
   - sel=2 at duty 0, rest pulsed -> duty stays 0.
   - Drive duty to 255, then pulse sum -> duty stays 255.
   - Both buttons low for 50 clocks -> no change.
   - sel=5 is not applicable at CH_BITS=2; with CHANNELS=3, sel=3 plus sum -> no change and duty_top = 0.
5. mode_top=1 mid-period, channel 0 duty set to 64:
   - The change takes effect only at the next rdy_top.
   - Afterwards rdy_top is spaced 1020 clocks apart.
   - pwm_top[0] high for 127 ticks = 254 clocks per period, centred on cnt=0.
6. Assert rst_top for 1 ns mid-period, with no clock edge during the pulse:
   - pwm_top, rdy_top, cnt_top and duty_top read 0 during the pulse.
   - First rdy_top comes 512 clocks after release.
